// File: rtl/risp_fire_collector_pkg.sv
// Shared types and helpers for the RISP fire collector.
// Holds the controller state encoding, index width and saturating add.
package risp_fire_collector_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DRAIN
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Increment v unless it already holds the all-ones value of width w.
  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input int unsigned w
  );
    logic [31:0] mx;
    mx = (32'd1 << w) - 32'd1;
    return (v >= mx) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/risp_fire_counter.sv
// One per-neuron saturating fire counter with clear and sample enable.
// Ports: clk, rst, i_clr, i_smp, i_fire, o_count; with
// RISP_FIRE_COLLECTOR_TIMESTAMP_EN also i_step (current sampled step)
// and o_first (step of first fire, all-ones if none).
module risp_fire_counter
  import risp_fire_collector_pkg::*;
#(
  parameter int COUNT_WIDTH = 8,
  parameter int RUN_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_clr,
  input  logic                   i_smp,
  input  logic                   i_fire,
`ifdef RISP_FIRE_COLLECTOR_TIMESTAMP_EN
  input  logic [RUN_WIDTH-1:0]   i_step,
  output logic [RUN_WIDTH-1:0]   o_first,
`endif
  output logic [COUNT_WIDTH-1:0] o_count
);

  logic [COUNT_WIDTH-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_smp && i_fire) begin
      r_cnt <= COUNT_WIDTH'(sat_inc(32'(r_cnt), COUNT_WIDTH));
    end
  end

  assign o_count = r_cnt;

`ifdef RISP_FIRE_COLLECTOR_TIMESTAMP_EN
  logic                 r_seen;
  logic [RUN_WIDTH-1:0] r_first;

  // A separate seen flag keeps a genuine fire at step all-ones distinct
  // from "never fired".
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_seen  <= 1'b0;
      r_first <= '1;
    end else if (i_smp && i_fire && !r_seen) begin
      r_seen  <= 1'b1;
      r_first <= i_step;
    end
  end

  assign o_first = r_first;
`endif

endmodule

// File: rtl/risp_fire_collector.sv
// Runs the RISP network for a requested number of timesteps, counts
// output-neuron fires, then streams one count per beat (valid/ready).
// Ports: clk, rst, fire, net_en, run_valid/run_ready/run_cycles,
// out_valid/out_ready/out_idx/out_count/out_last.
// Macro RISP_FIRE_COLLECTOR_TIMESTAMP_EN adds out_first (first-fire step).
module risp_fire_collector
  import risp_fire_collector_pkg::*;
#(
  parameter int NUM_OUT         = 4,
  parameter int COUNT_WIDTH     = 8,
  parameter int RUN_WIDTH       = 16,
  parameter int FIRE_REGISTERED = 0,
  localparam int IW = idx_w(NUM_OUT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_OUT-1:0]     fire,
  output logic                   net_en,
  input  logic                   run_valid,
  output logic                   run_ready,
  input  logic [RUN_WIDTH-1:0]   run_cycles,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IW-1:0]          out_idx,
`ifdef RISP_FIRE_COLLECTOR_TIMESTAMP_EN
  output logic [RUN_WIDTH-1:0]   out_first,
`endif
  output logic [COUNT_WIDTH-1:0] out_count,
  output logic                   out_last
);

  state_t                 r_state;
  state_t                 w_next;
  logic [RUN_WIDTH-1:0]   r_remain;
  logic [IW-1:0]          r_idx;
  logic                   r_en_d;
  logic                   w_acc;
  logic                   w_hs;
  logic                   w_smp;
  logic [COUNT_WIDTH-1:0] w_cnt [NUM_OUT];

  assign w_acc = run_valid && run_ready;
  assign w_hs  = out_valid && out_ready;
  // Registered neurons report a timestep's fire one cycle after its en.
  assign w_smp = (FIRE_REGISTERED != 0) ? r_en_d : net_en;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_acc) w_next = (run_cycles != '0) ? RUN : DRAIN;
      end
      RUN: begin
        if (r_remain == RUN_WIDTH'(1))
          w_next = (FIRE_REGISTERED != 0) ? FLUSH : DRAIN;
      end
      FLUSH: w_next = DRAIN;
      DRAIN: begin
        if (w_hs && out_last) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    run_ready = (r_state == IDLE) && !rst;
    net_en    = (r_state == RUN) && !rst;
    out_valid = (r_state == DRAIN) && !rst;
    out_last  = out_valid && (r_idx == IW'(NUM_OUT - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_remain <= '0;
      r_en_d   <= 1'b0;
      r_idx    <= '0;
    end else begin
      r_en_d <= net_en;
      if (w_acc)
        r_remain <= run_cycles;
      else if (r_state == RUN)
        r_remain <= r_remain - 1'b1;
      if (w_hs)
        r_idx <= out_last ? '0 : r_idx + 1'b1;
    end
  end

  assign out_idx   = r_idx;
  assign out_count = w_cnt[r_idx];

`ifdef RISP_FIRE_COLLECTOR_TIMESTAMP_EN
  logic [RUN_WIDTH-1:0] r_step;
  logic [RUN_WIDTH-1:0] w_first [NUM_OUT];

  always_ff @(posedge clk) begin
    if (rst || w_acc) r_step <= '0;
    else if (w_smp)   r_step <= r_step + 1'b1;
  end

  assign out_first = w_first[r_idx];
`endif

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_cnt
    risp_fire_counter #(
      .COUNT_WIDTH(COUNT_WIDTH),
      .RUN_WIDTH  (RUN_WIDTH)
    ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_acc),
      .i_smp  (w_smp),
      .i_fire (fire[g]),
`ifdef RISP_FIRE_COLLECTOR_TIMESTAMP_EN
      .i_step (r_step),
      .o_first(w_first[g]),
`endif
      .o_count(w_cnt[g])
    );
  end

endmodule

// File: tb/tb_risp_fire_collector.sv
// Scoreboard bench for risp_fire_collector: a combinational-fire and a
// registered-fire instance share stimulus; a monitor checks every beat.
module tb_risp_fire_collector;

  typedef struct packed {
    logic [15:0] first;
    logic        last;
    logic [2:0]  cnt;
    logic [1:0]  idx;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  fire = '0;
  logic [3:0]  fire_d = '0;
  logic        run_valid = 1'b0;
  logic [15:0] run_cycles = '0;
  logic        out_ready = 1'b1;

  logic        net_en0, run_ready0, out_valid0, out_last0;
  logic [1:0]  out_idx0;
  logic [2:0]  out_count0;
  logic        net_en1, run_ready1, out_valid1, out_last1;
  logic [1:0]  out_idx1;
  logic [2:0]  out_count1;
`ifdef RISP_FIRE_COLLECTOR_TIMESTAMP_EN
  logic [15:0] out_first0, out_first1;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  beat_t q0[$];
  beat_t q1[$];
  logic [3:0] pat [0:31];

  int    en_cnt [2] = '{0, 0};
  int    last_en[2] = '{0, 0};
  int    first_v[2] = '{0, 0};
  int    hs     [2] = '{0, 0};
  logic  pv     [2] = '{1'b0, 1'b0};
  logic  hv     [2] = '{1'b0, 1'b0};
  beat_t hb     [2];

  risp_fire_collector #(
    .NUM_OUT(4), .COUNT_WIDTH(3), .RUN_WIDTH(16), .FIRE_REGISTERED(0)
  ) dut0 (
    .clk(clk), .rst(rst), .fire(fire), .net_en(net_en0),
    .run_valid(run_valid), .run_ready(run_ready0),
    .run_cycles(run_cycles), .out_valid(out_valid0),
    .out_ready(out_ready), .out_idx(out_idx0),
`ifdef RISP_FIRE_COLLECTOR_TIMESTAMP_EN
    .out_first(out_first0),
`endif
    .out_count(out_count0), .out_last(out_last0)
  );

  risp_fire_collector #(
    .NUM_OUT(4), .COUNT_WIDTH(3), .RUN_WIDTH(16), .FIRE_REGISTERED(1)
  ) dut1 (
    .clk(clk), .rst(rst), .fire(fire_d), .net_en(net_en1),
    .run_valid(run_valid), .run_ready(run_ready1),
    .run_cycles(run_cycles), .out_valid(out_valid1),
    .out_ready(out_ready), .out_idx(out_idx1),
`ifdef RISP_FIRE_COLLECTOR_TIMESTAMP_EN
    .out_first(out_first1),
`endif
    .out_count(out_count1), .out_last(out_last1)
  );

  always #5 clk = ~clk;

  // Model of neurons that register fire: one cycle behind the stimulus.
  always @(posedge clk) fire_d <= fire;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic mon(input int d, input logic v, input logic en,
                     input beat_t b);
    beat_t e;
    bit emp;
    if (en) begin
      en_cnt[d]++;
      last_en[d] = cyc;
    end
    if (v && !pv[d]) first_v[d] = cyc;
    pv[d] = v;
    if (!v) begin
      hv[d] = 1'b0;
    end else begin
      if (hv[d]) chk($sformatf("hold%0d", d), 32'(b), 32'(hb[d]));
      if (out_ready) begin
        hv[d] = 1'b0;
        hs[d]++;
        emp = 1'b0;
        if (d == 0) begin
          if (q0.size() > 0) e = q0.pop_front(); else emp = 1'b1;
        end else begin
          if (q1.size() > 0) e = q1.pop_front(); else emp = 1'b1;
        end
        if (emp) begin
          n_tests++;
          n_fail++;
          $display("FAIL beat%0d: got idx %0d expected no beat", d, b.idx);
        end else begin
          chk($sformatf("idx%0d", d), 32'(b.idx), 32'(e.idx));
          chk($sformatf("cnt%0d_%0d", d, e.idx), 32'(b.cnt), 32'(e.cnt));
          chk($sformatf("last%0d_%0d", d, e.idx), 32'(b.last), 32'(e.last));
`ifdef RISP_FIRE_COLLECTOR_TIMESTAMP_EN
          chk($sformatf("first%0d_%0d", d, e.idx), 32'(b.first),
              32'(e.first));
`endif
        end
      end else begin
        hv[d] = 1'b1;
        hb[d] = b;
      end
    end
  endtask

  always @(negedge clk) begin
    beat_t b;
    b = '0;
    b.idx = out_idx0; b.cnt = out_count0; b.last = out_last0;
`ifdef RISP_FIRE_COLLECTOR_TIMESTAMP_EN
    b.first = out_first0;
`endif
    mon(0, out_valid0, net_en0, b);
    b = '0;
    b.idx = out_idx1; b.cnt = out_count1; b.last = out_last1;
`ifdef RISP_FIRE_COLLECTOR_TIMESTAMP_EN
    b.first = out_first1;
`endif
    mon(1, out_valid1, net_en1, b);
  end

  task automatic push(input logic [2:0] c0, c1, c2, c3,
                      input logic [15:0] f0, f1, f2, f3);
    logic [2:0]  c [4];
    logic [15:0] f [4];
    beat_t e;
    c = '{c0, c1, c2, c3};
    f = '{f0, f1, f2, f3};
    for (int i = 0; i < 4; i++) begin
      e.idx = 2'(i); e.cnt = c[i]; e.last = (i == 3); e.first = f[i];
      q0.push_back(e);
      q1.push_back(e);
    end
  endtask

  task automatic clr_pat();
    for (int i = 0; i < 32; i++) pat[i] = '0;
  endtask

  task automatic wait_ready();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (run_ready0 && run_ready1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wait_ready: got %0b%0b expected 11 within 100 cycles",
               run_ready0, run_ready1);
    end
  endtask

  task automatic do_run(input int n, input bit tog);
    int e0, e1, h0, h1, acc;
    logic [5:0] seq;
    seq = 6'b101001;
    wait_ready();
    e0 = en_cnt[0]; e1 = en_cnt[1]; h0 = hs[0]; h1 = hs[1];
    run_valid = 1'b1;
    run_cycles = 16'(n);
    @(posedge clk); #1;
    acc = cyc - 1;
    run_valid = 1'b0;
    run_cycles = 16'h0003;
    for (int c = 1; c <= n; c++) begin
      fire = pat[c];
      @(posedge clk); #1;
    end
    fire = '0;
    if (tog) begin
      for (int i = 0; i < 6; i++) begin
        out_ready = seq[i];
        @(posedge clk); #1;
      end
      out_ready = 1'b1;
    end
    wait_ready();
    chk($sformatf("en0_n%0d", n), 32'(en_cnt[0] - e0), 32'(n));
    chk($sformatf("en1_n%0d", n), 32'(en_cnt[1] - e1), 32'(n));
    chk($sformatf("hs0_n%0d", n), 32'(hs[0] - h0), 32'd4);
    chk($sformatf("hs1_n%0d", n), 32'(hs[1] - h1), 32'd4);
    if (n > 0) begin
      chk("lat0", 32'(first_v[0] - last_en[0]), 32'd1);
      chk("lat1", 32'(first_v[1] - last_en[1]), 32'd2);
    end else begin
      chk("lat0_zero", 32'(first_v[0] - acc), 32'd1);
      chk("lat1_zero", 32'(first_v[1] - acc), 32'd1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish by 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_pat();
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_run_ready0", 32'(run_ready0), 32'd0);
    chk("rst_run_ready1", 32'(run_ready1), 32'd0);
    chk("rst_net_en0", 32'(net_en0), 32'd0);
    chk("rst_out_valid0", 32'(out_valid0), 32'd0);
    chk("rst_out_idx0", 32'(out_idx0), 32'd0);
    chk("rst_out_last0", 32'(out_last0), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_run_ready0", 32'(run_ready0), 32'd1);
    @(posedge clk); #1;

    // Abort a 10-cycle run with reset in its third cycle.
    run_valid = 1'b1;
    run_cycles = 16'd10;
    fire = 4'hF;
    @(posedge clk); #1;
    run_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    fire = '0;
    @(negedge clk);
    chk("abort_net_en0", 32'(net_en0), 32'd0);
    chk("abort_net_en1", 32'(net_en1), 32'd0);
    chk("abort_run_ready0", 32'(run_ready0), 32'd1);
    chk("abort_run_ready1", 32'(run_ready1), 32'd1);
    chk("abort_out_valid0", 32'(out_valid0), 32'd0);
    @(posedge clk); #1;

    // 5 steps: neuron0 every step, neuron2 on steps 2 and 4.
    clr_pat();
    pat[1] = 4'b0001; pat[2] = 4'b0101; pat[3] = 4'b0001;
    pat[4] = 4'b0101; pat[5] = 4'b0001;
    push(3'd5, 3'd0, 3'd2, 3'd0, 16'd0, 16'hFFFF, 16'd1, 16'hFFFF);
    do_run(5, 1'b0);

    // 20 steps with neuron1 always firing: 3-bit counter sticks at 7.
    clr_pat();
    for (int i = 1; i <= 20; i++) pat[i] = 4'b0010;
    push(3'd0, 3'd7, 3'd0, 3'd0, 16'hFFFF, 16'd0, 16'hFFFF, 16'hFFFF);
    do_run(20, 1'b0);

    // Zero-length run: straight to draining four zero counts.
    clr_pat();
    push(3'd0, 3'd0, 3'd0, 3'd0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    do_run(0, 1'b0);

    // 4 steps, first fires at step index 2, with downstream stalls.
    clr_pat();
    pat[3] = 4'b1010; pat[4] = 4'b0010;
    push(3'd0, 3'd2, 3'd0, 3'd1, 16'hFFFF, 16'd2, 16'hFFFF, 16'd2);
    do_run(4, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    chk("q0_empty", 32'(q0.size()), 32'd0);
    chk("q1_empty", 32'(q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
